pipe_reg_elastic: RTL and testbench

PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

---
 rtl/pipe_reg_elastic.sv | 124 ++++++++++++
 tb/tb_pipe_reg_elastic.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// ---------------------------------------------------------------------------
// pipe_reg_elastic
//   Elastic valid/ready register pipeline of STAGES stages. Each stage holds
//   one payload and a valid bit. Back-pressure travels through a
//   combinational ready chain, so an empty stage (bubble) always accepts
//   data even while the stages downstream of it are stalled. A per-stage
//   flush vector kills payloads, and a saturating counter records how many
//   payloads were killed.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   upstream offers a payload
//   in_data    in   upstream payload [DATA_WIDTH]
//   in_ready   out  stage 0 can accept this cycle
//   out_valid  out  last stage holds a valid payload
//   out_data   out  last-stage payload [DATA_WIDTH]
//   out_ready  in   downstream accepts this cycle
//   flush      in   per-stage kill vector [STAGES], bit i -> stage i
//   occupancy  out  number of valid stages (registered)
//   flush_cnt  out  saturating count of payloads killed by flush [16]
// ---------------------------------------------------------------------------
module pipe_reg_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    localparam int OCC_W     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic [STAGES-1:0]     flush,
    output logic [OCC_W-1:0]      occupancy,
    output logic [15:0]           flush_cnt
);

    logic [STAGES:0]         ready;
    logic [STAGES-1:0]       v_q;
    logic [STAGES-1:0]       v_d;
    // Valid bits as they would be after the edge if no flush were applied;
    // used to count the payloads that flush actually kills.
    logic [STAGES-1:0]       v_pre;
    logic [DATA_WIDTH-1:0]   d_q [STAGES];
    logic [DATA_WIDTH-1:0]   d_d [STAGES];
    logic [OCC_W-1:0]        occ_q;
    logic [OCC_W-1:0]        occ_d;
    logic [15:0]             flush_cnt_q;
    logic [15:0]             flush_cnt_d;
    logic [3:0]              kill_n;
    logic [16:0]             cnt_sum;

    // Ready chain, evaluated from the output back towards the input so that
    // a single empty stage anywhere downstream frees every stage above it.
    always_comb begin
        ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready[i] = !v_q[i] | ready[i+1];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic                  src_valid;
            logic [DATA_WIDTH-1:0] src_data;
            logic                  take;

            if (gi == 0) begin : g_src_in
                assign src_valid = in_valid;
                assign src_data  = in_data;
            end else begin : g_src_prev
                assign src_valid = v_q[gi-1];
                assign src_data  = d_q[gi-1];
            end

            assign take      = ready[gi] & src_valid;
            // A ready stage takes whatever its source offers (possibly a
            // bubble); a stalled stage holds.
            assign v_pre[gi] = ready[gi] ? src_valid : v_q[gi];
            assign v_d[gi]   = v_pre[gi] & ~flush[gi];
            // Data only moves on a real transfer; invalid stages keep stale data.
            assign d_d[gi]   = take ? src_data : d_q[gi];
        end
    endgenerate

    always_comb begin
        occ_d  = '0;
        kill_n = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d  = occ_d + OCC_W'(v_d[i]);
            kill_n = kill_n + 4'(v_pre[i] & flush[i]);
        end
        cnt_sum     = {1'b0, flush_cnt_q} + 17'(kill_n);
        flush_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q         <= '0;
            occ_q       <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q         <= v_d;
            occ_q       <= occ_d;
            flush_cnt_q <= flush_cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_elastic
//   Bench for pipe_reg_elastic with STAGES=3, DATA_WIDTH=16. A reference
//   model of slots plus a payload queue predicts every output; departures
//   are pushed into a scoreboard queue and a separate monitor pops them
//   whenever the DUT presents a payload that downstream accepts.
// ---------------------------------------------------------------------------
module tb_pipe_reg_elastic;

    localparam int S = 3;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [S-1:0]  flush;
    logic [1:0]    occupancy;
    logic [15:0]   flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit            mv [S];
    logic [W-1:0]  md [S];
    int            mcnt;
    logic [W-1:0]  exp_q [$];

    pipe_reg_elastic #(.DATA_WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // A stage can accept if downstream accepts or any stage at or below it
    // (towards the output) is empty: that hole lets everything above shift.
    function automatic bit m_ready(input int i, input bit ordy);
        if (ordy) return 1'b1;
        for (int j = i; j < S; j++) if (!mv[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < S; i++) if (mv[i]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        mcnt = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit iv, input logic [W-1:0] id, input bit ordy,
                              input logic [S-1:0] fl);
        bit           rdy [S];
        bit           nv  [S];
        logic [W-1:0] nd  [S];
        bit           sv;
        logic [W-1:0] sd;
        int           killed = 0;
        for (int i = 0; i < S; i++) rdy[i] = m_ready(i, ordy);
        for (int i = 0; i < S; i++) begin
            nv[i] = mv[i];
            nd[i] = md[i];
            sv    = (i == 0) ? iv : mv[i-1];
            sd    = (i == 0) ? id : md[i-1];
            if (rdy[i]) begin
                nv[i] = sv;
                if (sv) nd[i] = sd;
            end
            if (fl[i]) begin
                if (nv[i]) killed++;
                nv[i] = 1'b0;
            end
        end
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
        mcnt = (mcnt + killed > 65535) ? 65535 : mcnt + killed;
    endtask

    // One clock cycle: drive inputs mid-cycle, check outputs against the
    // model, queue the expected departure, then advance the model.
    task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                        input logic [S-1:0] fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("in_ready",  32'(in_ready),  32'(m_ready(0, ordy)));
        chk("out_valid", 32'(out_valid), 32'(mv[S-1]));
        chk("out_data",  32'(out_data),  32'(md[S-1]));
        chk("occupancy", 32'(occupancy), 32'(m_occ()));
        chk("flush_cnt", 32'(flush_cnt), 32'(mcnt));
        if (mv[S-1] && ordy) exp_q.push_back(md[S-1]);
        model_edge(iv, id, ordy, fl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = '0;
        model_clear();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain();
        repeat (S + 1) step(1'b0, '0, 1'b1, '0);
    endtask

    // Scoreboard monitor: independent of the driver, pops on every accepted output.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none t=%0t", out_data, $time);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL sb_data actual=%0h expected=%0h t=%0t", out_data, e, $time);
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;
        model_clear();

        // Streaming with out_ready held high
        do_reset();
        step(1'b1, 16'h1, 1'b1, '0);
        step(1'b1, 16'h2, 1'b1, '0);
        step(1'b1, 16'h3, 1'b1, '0);
        @(posedge clk); #1;
        chk("stream_first_valid", 32'(out_valid), 32'd1);
        chk("stream_first_data",  32'(out_data),  32'h1);
        drain();

        // Back-pressure and release
        do_reset();
        step(1'b1, 16'h1, 1'b0, '0);
        step(1'b1, 16'h2, 1'b0, '0);
        step(1'b1, 16'h3, 1'b0, '0);
        @(posedge clk); #1;
        chk("bp_occupancy", 32'(occupancy), 32'd3);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        step(1'b1, 16'h4, 1'b0, '0);
        step(1'b1, 16'h4, 1'b1, '0);
        @(posedge clk); #1;
        chk("bp_release_occ",  32'(occupancy), 32'd3);
        chk("bp_release_data", 32'(out_data),  32'h2);
        drain();

        // Bubble collapse
        do_reset();
        step(1'b1, 16'h55, 1'b0, '0);
        step(1'b0, 16'h0,  1'b0, '0);
        step(1'b0, 16'h0,  1'b0, '0);
        step(1'b1, 16'hA,  1'b0, '0);
        step(1'b1, 16'hA,  1'b0, '0);
        @(posedge clk); #1;
        chk("bubble_occupancy", 32'(occupancy), 32'd3);
        chk("bubble_out_data",  32'(out_data),  32'h55);
        drain();

        // Selective flush
        do_reset();
        step(1'b1, 16'h11, 1'b0, '0);
        step(1'b1, 16'h12, 1'b0, '0);
        step(1'b1, 16'h13, 1'b0, '0);
        step(1'b0, 16'h0,  1'b0, 3'b011);
        @(posedge clk); #1;
        chk("sflush_occupancy", 32'(occupancy), 32'd1);
        chk("sflush_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("sflush_out_data",  32'(out_data),  32'h11);
        drain();

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6,
                 ($urandom_range(0, 7) == 0) ? S'($urandom) : S'(0));
        end
        drain();

        // Asynchronous reset between clock edges
        step(1'b1, 16'h21, 1'b1, '0);
        step(1'b1, 16'h22, 1'b1, '0);
        step(1'b1, 16'h23, 1'b1, '0);
        @(posedge clk); #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_occupancy", 32'(occupancy), 32'd0);
        chk("async_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 16'h31, 1'b1, '0);
        drain();

        // Counter saturation: one kill per cycle up to FFFE, then a full flush
        do_reset();
        for (int n = 0; n < 65534; n++) step(1'b1, W'($urandom), 1'b1, 3'b001);
        @(posedge clk); #1;
        chk("sat_pre", 32'(flush_cnt), 32'hFFFE);
        step(1'b1, 16'h41, 1'b0, '0);
        step(1'b1, 16'h42, 1'b0, '0);
        step(1'b1, 16'h43, 1'b0, '0);
        step(1'b0, 16'h0,  1'b0, 3'b111);
        @(posedge clk); #1;
        chk("sat_flush_cnt", 32'(flush_cnt), 32'hFFFF);
        chk("sat_out_valid", 32'(out_valid), 32'd0);
        step(1'b1, 16'h44, 1'b1, 3'b001);
        step(1'b0, 16'h0,  1'b1, '0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
